multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  single rising-edge clock.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: op  in  7  opcode, Instr[6:0] from instruction register.
REQ-004 SHALL have: funct3  in  3  Instr[14:12].
REQ-005 SHALL have: funct7b5  in  1  Instr[30].
REQ-006 SHALL have: Zero  in  1  ALU zero flag.
REQ-007 SHALL have: ImmSrc  out  3  immediate format to extender: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-008 SHALL have: ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
REQ-009 SHALL have: ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4.
REQ-010 SHALL have: ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
REQ-011 SHALL have: ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 SHALL have: AdrSrc  out  1  memory address mux, 0 PC, 1 Result.
REQ-013 SHALL have single-bit outputs: IRWrite, PCWrite, RegWrite, MemWrite, each an active-high write enable.

Function
REQ-014 SHALL implement a Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI.
REQ-015 SHALL transition: FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, 0110111->LUI, any other->FETCH.
REQ-016 SHALL transition: MEMADR->MEMREAD if op=0000011, else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ, LUI->FETCH.
REQ-017 SHALL drive in FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10, PCUpdate=1.
REQ-018 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp add (branch target into ALUOut).
REQ-019 SHALL drive: MEMADR ALUSrcA=10, ALUSrcB=01, add; MEMREAD ResultSrc=00, AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MEMWRITE ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-020 SHALL drive: EXECUTER ALUSrcA=10, ALUSrcB=00, funct-decoded op; EXECUTEI ALUSrcA=10, ALUSrcB=01, funct-decoded op; ALUWB ResultSrc=00, RegWrite=1.
REQ-021 SHALL drive: BEQ ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1; JAL ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1; LUI ResultSrc=11, RegWrite=1.
REQ-022 SHALL hold every control not listed for a state at 0 (write enables deasserted, mux selects 00, ALUOp add).
REQ-023 SHALL compute PCWrite = PCUpdate OR (Branch AND Zero), combinationally in the current cycle.
REQ-024 SHALL decode ImmSrc combinationally from op in every state: 0000011/0010011->000, 0100011->001, 1100011->010, 0110111->011, 1101111->100, other->000.
REQ-025 SHALL decode funct ALU op from funct3: 000->sub if op[5] AND funct7b5 else add; 010->slt; 110->or; 111->and; any other->add.
REQ-026 SHALL give instruction latencies, FETCH to FETCH inclusive: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, lui 3, unknown opcode 2 cycles.
REQ-027 SHALL assert at most one of RegWrite, MemWrite in any cycle; IRWrite only in FETCH.

Reset
REQ-028 SHALL load state FETCH on any rising clk with reset=1, including mid-instruction; pending writes are abandoned.
REQ-029 SHALL force IRWrite, PCWrite, RegWrite, MemWrite to 0 while reset=1; other outputs follow FETCH values.
REQ-030 SHALL present FETCH outputs (IRWrite=1, PCWrite=1) in the first cycle after reset deasserts.

Verification
REQ-031 lw (op=0000011): reset release -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=000 throughout.
REQ-032 sw (op=0100011): MemWrite=1 only in cycle 4 with AdrSrc=1; ImmSrc=001; RegWrite never 1.
REQ-033 beq with Zero=1 in cycle 3 -> PCWrite=1, ALUControl=001, ImmSrc=010; repeat with Zero=0 -> PCWrite=0 in cycle 3.
REQ-034 R-type funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; I-type same funct3/funct7b5 -> ALUControl=000; funct3=111 -> 010.
REQ-035 op=1111111 -> FETCH, DECODE, FETCH with no RegWrite/MemWrite; lui -> RegWrite=1, ResultSrc=11, ImmSrc=011 in cycle 3.
REQ-036 reset=1 asserted during MEMREAD of lw -> next state FETCH, MEMWB never entered, no RegWrite pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RISC-V style datapath (lw, sw, R-type, I-ALU,
// beq, jal, lui). A Moore FSM walks each instruction through its datapath
// steps and drives mux selects, ALU operation and write enables.
//
// Ports
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous active-high reset
//   op          in   7  opcode, Instr[6:0]
//   funct3      in   3  Instr[14:12]
//   funct7b5    in   1  Instr[30]
//   Zero        in   1  ALU zero flag
//   ImmSrc      out  3  000 I, 001 S, 010 B, 011 U, 100 J
//   ALUSrcA     out  2  00 PC, 01 OldPC, 10 RD1
//   ALUSrcB     out  2  00 WriteData, 01 ImmExt, 10 constant 4
//   ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   AdrSrc      out  1  memory address, 0 PC, 1 Result
//   IRWrite     out  1  instruction register write enable
//   PCWrite     out  1  PC write enable
//   RegWrite    out  1  register file write enable
//   MemWrite    out  1  data memory write enable
//
// State     | meaning
// ----------+-------------------------------------------------------------
// FETCH     | read instruction at PC into IR, PC <= PC + 4
// DECODE    | read registers, ALUOut <= OldPC + imm (branch/jump target)
// MEMADR    | ALUOut <= rs1 + imm (load/store address)
// MEMREAD   | read data memory at ALUOut
// MEMWB     | rd <= loaded data
// MEMWRITE  | data memory[ALUOut] <= rs2
// EXECUTER  | ALUOut <= rs1 op rs2
// EXECUTEI  | ALUOut <= rs1 op imm
// ALUWB     | rd <= ALUOut
// BEQ       | compare rs1 - rs2, PC <= ALUOut (target) when Zero
// JAL       | PC <= ALUOut (target), ALUOut <= OldPC + 4 (link)
// LUI       | rd <= ImmExt
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUI
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_e;

  state_e state_q, state_d;
  state_e state_out;   // state the outputs are decoded from

  aluop_e alu_op;
  logic   pc_update;
  logic   branch;
  logic   ir_write;
  logic   reg_write;
  logic   mem_write;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECUTER;
          OP_ITYPE:  state_d = S_EXECUTEI;
          OP_BRANCH: state_d = S_BEQ;
          OP_JAL:    state_d = S_JAL;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ,
      S_LUI:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is held the non-enable outputs present FETCH values, so the
  // output decode looks at FETCH instead of whatever state_q currently holds.
  assign state_out = reset ? S_FETCH : state_q;

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_out)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decode. Subtract only for R-type (op[5]=1) with funct7b5 set; the
  // I-type encoding reuses Instr[30] as an immediate bit, so addi never subs.
  // ---------------------------------------------------------------------------
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format, decoded from op regardless of state
  // ---------------------------------------------------------------------------
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD,
      OP_ITYPE:  ImmSrc = 3'b000;
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_LUI:    ImmSrc = 3'b011;
      OP_JAL:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write enables, all held low while reset is asserted
  // ---------------------------------------------------------------------------
  assign IRWrite  = ir_write  & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] imm;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic [2:0] alu;
    logic       adr;
    logic       ir;
    logic       pcw;
    logic       rw;
    logic       mw;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    out_t       exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  //                         imm  asa asb rs  alu  adr ir pcw rw mw
  localparam out_t O_RST   = 17'b000_00_10_10_000_0_0_0_0_0;
  localparam out_t O_FETCH = 17'b000_00_10_10_000_0_1_1_0_0;
  localparam out_t O_DEC   = 17'b000_01_01_00_000_0_0_0_0_0;
  localparam out_t O_MADR  = 17'b000_10_01_00_000_0_0_0_0_0;
  localparam out_t O_MRD   = 17'b000_00_00_00_000_1_0_0_0_0;
  localparam out_t O_MWB   = 17'b000_00_00_01_000_0_0_0_1_0;
  localparam out_t O_MWR   = 17'b000_00_00_00_000_1_0_0_0_1;
  localparam out_t O_EXR   = 17'b000_10_00_00_000_0_0_0_0_0;
  localparam out_t O_EXI   = 17'b000_10_01_00_000_0_0_0_0_0;
  localparam out_t O_ALUWB = 17'b000_00_00_00_000_0_0_0_1_0;
  localparam out_t O_BEQ0  = 17'b000_10_00_00_001_0_0_0_0_0;
  localparam out_t O_BEQ1  = 17'b000_10_00_00_001_0_0_1_0_0;
  localparam out_t O_JAL   = 17'b000_01_10_00_000_0_0_1_0_0;
  localparam out_t O_LUI   = 17'b000_00_00_11_000_0_0_0_1_0;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;
  vec_t tbl[$];
  sb_t  sb[$];

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite)
  );

  always #5 clk = ~clk;

  function automatic out_t wi(out_t b, logic [2:0] imm);
    out_t r = b;
    r.imm = imm;
    return r;
  endfunction

  function automatic out_t wa(out_t b, logic [2:0] imm, logic [2:0] alu);
    out_t r = b;
    r.imm = imm;
    r.alu = alu;
    return r;
  endfunction

  task automatic add(input string n, input logic r, input logic [6:0] o,
                     input logic [2:0] f3, input logic f7, input logic z,
                     input out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic cyc(input string n, input logic r, input logic [6:0] o,
                     input logic [2:0] f3, input logic f7, input logic z,
                     input out_t e);
    sb_t s;
    @(posedge clk);
    #1;
    reset = r; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    s.name = n;
    s.exp  = e;
    sb.push_back(s);
  endtask

  // Monitor: compare on the falling edge, away from the state update.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t  s;
      out_t act;
      s   = sb.pop_front();
      act = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
             AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite};
      n_tests++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got imm=%b asa=%b asb=%b rs=%b alu=%b adr=%b ir=%b pcw=%b rw=%b mw=%b, expected imm=%b asa=%b asb=%b rs=%b alu=%b adr=%b ir=%b pcw=%b rw=%b mw=%b",
                 s.name, act.imm, act.asa, act.asb, act.rs, act.alu, act.adr, act.ir, act.pcw, act.rw, act.mw,
                 s.exp.imm, s.exp.asa, s.exp.asb, s.exp.rs, s.exp.alu, s.exp.adr, s.exp.ir, s.exp.pcw, s.exp.rw, s.exp.mw);
      end
      n_tests++;
      if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
        n_fail++;
        $display("FAIL %s_excl: RegWrite=%b MemWrite=%b, required not both 1", s.name, RegWrite, MemWrite);
      end
    end
  end

  initial begin
    reset = 1'b1; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

    add("rst0", 1, OP_LW, 3'b000, 0, 0, O_RST);
    add("rst1", 1, OP_SW, 3'b000, 0, 0, wi(O_RST, 3'b001));
    // lw: 5 cycles
    add("lw_fetch", 0, OP_LW, 3'b010, 0, 0, O_FETCH);
    add("lw_dec",   0, OP_LW, 3'b010, 0, 0, O_DEC);
    add("lw_madr",  0, OP_LW, 3'b010, 0, 0, O_MADR);
    add("lw_mrd",   0, OP_LW, 3'b010, 0, 0, O_MRD);
    add("lw_mwb",   0, OP_LW, 3'b010, 0, 0, O_MWB);
    // sw: 4 cycles
    add("sw_fetch", 0, OP_SW, 3'b010, 0, 0, wi(O_FETCH, 3'b001));
    add("sw_dec",   0, OP_SW, 3'b010, 0, 0, wi(O_DEC,   3'b001));
    add("sw_madr",  0, OP_SW, 3'b010, 0, 0, wi(O_MADR,  3'b001));
    add("sw_mwr",   0, OP_SW, 3'b010, 0, 0, wi(O_MWR,   3'b001));
    // R-type sub
    add("sub_fetch", 0, OP_R, 3'b000, 1, 0, O_FETCH);
    add("sub_dec",   0, OP_R, 3'b000, 1, 0, O_DEC);
    add("sub_exr",   0, OP_R, 3'b000, 1, 0, wa(O_EXR, 3'b000, 3'b001));
    add("sub_wb",    0, OP_R, 3'b000, 1, 0, O_ALUWB);
    // I-type with Instr[30]=1: still add
    add("addi_fetch", 0, OP_I, 3'b000, 1, 0, O_FETCH);
    add("addi_dec",   0, OP_I, 3'b000, 1, 0, O_DEC);
    add("addi_exi",   0, OP_I, 3'b000, 1, 0, wa(O_EXI, 3'b000, 3'b000));
    add("addi_wb",    0, OP_I, 3'b000, 1, 0, O_ALUWB);
    // R-type and
    add("and_fetch", 0, OP_R, 3'b111, 0, 0, O_FETCH);
    add("and_dec",   0, OP_R, 3'b111, 0, 0, O_DEC);
    add("and_exr",   0, OP_R, 3'b111, 0, 0, wa(O_EXR, 3'b000, 3'b010));
    add("and_wb",    0, OP_R, 3'b111, 0, 0, O_ALUWB);
    // I-type slti, then R-type or, then R-type sll (decodes to add)
    add("slti_fetch", 0, OP_I, 3'b010, 0, 0, O_FETCH);
    add("slti_dec",   0, OP_I, 3'b010, 0, 0, O_DEC);
    add("slti_exi",   0, OP_I, 3'b010, 0, 0, wa(O_EXI, 3'b000, 3'b101));
    add("slti_wb",    0, OP_I, 3'b010, 0, 0, O_ALUWB);
    add("or_fetch",   0, OP_R, 3'b110, 0, 0, O_FETCH);
    add("or_dec",     0, OP_R, 3'b110, 0, 0, O_DEC);
    add("or_exr",     0, OP_R, 3'b110, 0, 0, wa(O_EXR, 3'b000, 3'b011));
    add("or_wb",      0, OP_R, 3'b110, 0, 0, O_ALUWB);
    add("sll_fetch",  0, OP_R, 3'b001, 1, 0, O_FETCH);
    add("sll_dec",    0, OP_R, 3'b001, 1, 0, O_DEC);
    add("sll_exr",    0, OP_R, 3'b001, 1, 0, wa(O_EXR, 3'b000, 3'b000));
    add("sll_wb",     0, OP_R, 3'b001, 1, 0, O_ALUWB);
    // beq taken (Zero high in DECODE must not write PC), then not taken
    add("beqt_fetch", 0, OP_BEQ, 3'b000, 0, 1, wi(O_FETCH, 3'b010));
    add("beqt_dec",   0, OP_BEQ, 3'b000, 0, 1, wi(O_DEC,   3'b010));
    add("beqt_beq",   0, OP_BEQ, 3'b000, 0, 1, wi(O_BEQ1,  3'b010));
    add("beqn_fetch", 0, OP_BEQ, 3'b000, 0, 0, wi(O_FETCH, 3'b010));
    add("beqn_dec",   0, OP_BEQ, 3'b000, 0, 0, wi(O_DEC,   3'b010));
    add("beqn_beq",   0, OP_BEQ, 3'b000, 0, 0, wi(O_BEQ0,  3'b010));
    // jal
    add("jal_fetch", 0, OP_JAL, 3'b000, 0, 0, wi(O_FETCH, 3'b100));
    add("jal_dec",   0, OP_JAL, 3'b000, 0, 0, wi(O_DEC,   3'b100));
    add("jal_jal",   0, OP_JAL, 3'b000, 0, 0, wi(O_JAL,   3'b100));
    add("jal_wb",    0, OP_JAL, 3'b000, 0, 0, wi(O_ALUWB, 3'b100));
    // lui
    add("lui_fetch", 0, OP_LUI, 3'b000, 0, 0, wi(O_FETCH, 3'b011));
    add("lui_dec",   0, OP_LUI, 3'b000, 0, 0, wi(O_DEC,   3'b011));
    add("lui_lui",   0, OP_LUI, 3'b000, 0, 0, wi(O_LUI,   3'b011));
    // unknown opcode: back to FETCH after DECODE
    add("bad_fetch", 0, OP_BAD, 3'b000, 0, 0, O_FETCH);
    add("bad_dec",   0, OP_BAD, 3'b000, 0, 0, O_DEC);
    add("bad_next",  0, OP_LW,  3'b000, 0, 0, O_FETCH);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].name, tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].exp);
    end

    // Reset during MEMREAD of lw: enables forced low, MEMWB never reached.
    cyc("rlw_dec",   0, OP_LW, 3'b010, 0, 0, O_DEC);
    cyc("rlw_madr",  0, OP_LW, 3'b010, 0, 0, O_MADR);
    cyc("rlw_mrd",   1, OP_LW, 3'b010, 0, 0, O_RST);
    cyc("rlw_fetch", 0, OP_LW, 3'b010, 0, 0, O_FETCH);
    cyc("rlw_dec2",  0, OP_LW, 3'b010, 0, 0, O_DEC);

    // Reset in the MEMWRITE cycle of sw: write abandoned, FETCH follows.
    cyc("rsw_madr",  0, OP_SW, 3'b000, 0, 0, wi(O_MADR,  3'b001));
    cyc("rsw_mwr",   1, OP_SW, 3'b000, 0, 0, wi(O_RST,   3'b001));
    cyc("rsw_fetch", 0, OP_SW, 3'b000, 0, 0, wi(O_FETCH, 3'b001));

    // Reset in BEQ with Zero=1: PCWrite must stay low.
    cyc("rbq_dec",   0, OP_BEQ, 3'b000, 0, 1, wi(O_DEC,   3'b010));
    cyc("rbq_beq",   1, OP_BEQ, 3'b000, 0, 1, wi(O_RST,   3'b010));
    cyc("rbq_fetch", 0, OP_BEQ, 3'b000, 0, 1, wi(O_FETCH, 3'b010));

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, expected completion by 20000");
      $fatal(1, "timeout");
    end
  end

endmodule
